// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Build macro DELAY_SLOT_EN selects delayed (branch delay slot) redirects.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_req,
    output logic [31:0] epc,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] next_seq(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] instr_pc_r, instr_pc_s;
    logic [31:0] epc_r, epc_s;
    logic        valid_r, valid_s;
    logic        req_r, req_s;

    logic        active_s;
    logic        exc_s;
    logic        redir_now_s;
    logic        event_s;
    logic        fetch_s;
    logic        accept_s;
    logic [31:0] redir_tgt_s;

`ifdef DELAY_SLOT_EN
    logic        pend_r, pend_s;
    logic [31:0] pend_tgt_r, pend_tgt_s;
    logic        slot_r, slot_s;
    logic        capture_s;
`endif

    // Event decode: exceptions outrank redirects; both are ignored in IDLE.
    always_comb begin
        active_s    = (state_r != ST_IDLE);
        exc_s       = exc_req && active_s;
        redir_tgt_s = word_align(redirect_target);
`ifdef DELAY_SLOT_EN
        capture_s   = redirect_valid && active_s && !exc_req;
        redir_now_s = 1'b0;
`else
        redir_now_s = redirect_valid && active_s && !exc_req;
`endif
        event_s     = exc_s || redir_now_s;
        fetch_s     = (state_r == ST_REQ) && imem_ack;
        accept_s    = (state_r == ST_HOLD) && instr_ready;
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_VECTOR;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            instr_r    <= 32'h0000_0000;
            instr_pc_r <= 32'h0000_0000;
            epc_r      <= 32'h0000_0000;
`ifdef DELAY_SLOT_EN
            pend_r     <= 1'b0;
            pend_tgt_r <= 32'h0000_0000;
            slot_r     <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_r      <= req_s;
            valid_r    <= valid_s;
            instr_r    <= instr_s;
            instr_pc_r <= instr_pc_s;
            epc_r      <= epc_s;
`ifdef DELAY_SLOT_EN
            pend_r     <= pend_s;
            pend_tgt_r <= pend_tgt_s;
            slot_r     <= slot_s;
`endif
        end
    end

    // Next-state selection; a request left outstanding by an event is drained.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
            end
            ST_REQ: begin
                if (event_s) begin
                    state_s = imem_ack ? ST_REQ : ST_DRAIN;
                end else if (imem_ack) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (event_s || instr_ready) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                state_s = imem_ack ? ST_REQ : ST_DRAIN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath updates; imem_req is registered from the next state.
    always_comb begin
        pc_s       = pc_r;
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;
        epc_s      = epc_r;
        valid_s    = valid_r;
        req_s      = (state_s == ST_REQ) || (state_s == ST_DRAIN);
        if (exc_s) begin
            epc_s   = valid_r ? instr_pc_r : pc_r;
            pc_s    = EXC_VECTOR;
            valid_s = 1'b0;
        end else if (redir_now_s) begin
            pc_s    = redir_tgt_s;
            valid_s = 1'b0;
        end else if (fetch_s) begin
            instr_s    = imem_rdata;
            instr_pc_s = pc_r;
            valid_s    = 1'b1;
            pc_s       = next_seq(pc_r);
        end else if (accept_s) begin
            valid_s = 1'b0;
`ifdef DELAY_SLOT_EN
            // Accepting the delay slot applies the newest pending target.
            if (pend_r && slot_r) begin
                pc_s = capture_s ? redir_tgt_s : pend_tgt_r;
            end else begin
                pc_s = pc_r;
            end
`endif
        end else begin
            valid_s = valid_r;
        end
    end

`ifdef DELAY_SLOT_EN
    // Pending redirect bookkeeping; slot_r marks that the delay slot was fetched.
    always_comb begin
        pend_s     = pend_r;
        pend_tgt_s = pend_tgt_r;
        slot_s     = slot_r;
        if (exc_s) begin
            pend_s = 1'b0;
            slot_s = 1'b0;
        end else begin
            if (capture_s) begin
                pend_s     = 1'b1;
                pend_tgt_s = redir_tgt_s;
                slot_s     = pend_r ? slot_r : 1'b0;
            end else begin
                pend_s = pend_r;
            end
            if (fetch_s && (pend_r || capture_s)) begin
                slot_s = 1'b1;
            end else if (accept_s && pend_r && slot_r) begin
                pend_s = 1'b0;
                slot_s = 1'b0;
            end else begin
                pend_tgt_s = pend_tgt_s;
            end
        end
    end
`endif

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr_valid = valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign epc         = epc_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed and randomized bench for pc_fetch_sequencer with a transaction-level reference model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h0000_0080;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic [31:0] epc;
    logic [31:0] pc;

    int n_checks;
    int n_pass;

    // Reference model: fetch in flight, word being dropped, word held for decode.
    logic        m_started;
    logic        m_req;
    logic        m_drop;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_epc;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic        m_slot;

    pc_fetch_sequencer #(
        .RESET_VECTOR (RST_VEC),
        .EXC_VECTOR   (EXC_VEC)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .epc             (epc),
        .pc              (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_req     = 1'b0;
        m_drop    = 1'b0;
        m_valid   = 1'b0;
        m_pc      = RST_VEC;
        m_instr   = 32'h0000_0000;
        m_ipc     = 32'h0000_0000;
        m_epc     = 32'h0000_0000;
        m_pend    = 1'b0;
        m_ptgt    = 32'h0000_0000;
        m_slot    = 1'b0;
    endtask

    task automatic model_step();
        logic        ack;
        logic        had_pend;
        logic [31:0] tgt;
        ack      = m_req && imem_ack;
        had_pend = m_pend;
        tgt      = {redirect_target[31:2], 2'b00};
        if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
        end else if (exc_req) begin
            m_epc   = m_valid ? m_ipc : m_pc;
            m_pc    = EXC_VEC;
            m_valid = 1'b0;
            m_drop  = m_req && !ack;
            m_req   = 1'b1;
            m_pend  = 1'b0;
            m_slot  = 1'b0;
`ifndef DELAY_SLOT_EN
        end else if (redirect_valid) begin
            m_pc    = tgt;
            m_valid = 1'b0;
            m_drop  = m_req && !ack;
            m_req   = 1'b1;
`endif
        end else begin
`ifdef DELAY_SLOT_EN
            if (redirect_valid) begin
                if (!had_pend) m_slot = 1'b0;
                m_pend = 1'b1;
                m_ptgt = tgt;
            end
`endif
            if (m_req) begin
                if (ack && m_drop) begin
                    m_drop = 1'b0;
                end else if (ack) begin
                    m_instr = imem_rdata;
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                    m_req   = 1'b0;
                    if (m_pend) m_slot = 1'b1;
                end
            end else if (instr_ready) begin
                m_valid = 1'b0;
                m_req   = 1'b1;
                if (had_pend && m_slot) begin
                    m_pc   = m_ptgt;
                    m_pend = 1'b0;
                    m_slot = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".imem_req"}, imem_req, m_req);
        check({tag, ".imem_addr"}, imem_addr, m_pc);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".instr_valid"}, instr_valid, m_valid);
        check({tag, ".instr"}, instr, m_instr);
        check({tag, ".instr_pc"}, instr_pc, m_ipc);
        check({tag, ".epc"}, epc, m_epc);
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all(tag);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset_n         = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0000_0000;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0000_0000;
        exc_req         = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all("reset");
        check("reset_pc", pc, RST_VEC);
        check("reset_req", imem_req, 1'b0);

        // Sequential fetch, ack and ready always high.
        reset_n     = 1'b1;
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        imem_rdata  = 32'h1111_0000;
        step("seq");
        check("seq_addr0", imem_addr, 32'h0000_0000);
        check("seq_req0", imem_req, 1'b1);
        step("seq");
        check("seq_valid0", instr_valid, 1'b1);
        check("seq_ipc0", instr_pc, 32'h0000_0000);
        step("seq");
        check("seq_addr4", imem_addr, 32'h0000_0004);
        step("seq");
        step("seq");
        check("seq_addr8", imem_addr, 32'h0000_0008);

        // Decode stalls for five cycles.
        instr_ready = 1'b0;
        step("stall");
        for (int i = 0; i < 5; i++) begin
            step("stall");
            check("stall_valid", instr_valid, 1'b1);
            check("stall_req", imem_req, 1'b0);
            check("stall_pc", pc, 32'h0000_000C);
            check("stall_ipc", instr_pc, 32'h0000_0008);
        end

        // Unaligned redirect while holding.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0103;
        step("redir");
        redirect_valid  = 1'b0;
`ifndef DELAY_SLOT_EN
        check("redir_valid", instr_valid, 1'b0);
        check("redir_addr", imem_addr, 32'h0000_0100);
`endif

        // Exception with the ack held back three cycles.
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        step("exc");
        exc_req = 1'b1;
        step("exc");
        exc_req = 1'b0;
`ifndef DELAY_SLOT_EN
        check("exc_epc", epc, 32'h0000_0100);
        check("exc_pc", pc, EXC_VEC);
        check("exc_req_held", imem_req, 1'b1);
`endif
        step("exc");
        step("exc");
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step("drain");
        check("drain_valid", instr_valid, 1'b0);
        check("drain_addr", imem_addr, EXC_VEC);
        imem_rdata = 32'h2222_0080;
        step("vec");
        check("vec_instr", instr, 32'h2222_0080);
        check("vec_ipc", instr_pc, EXC_VEC);

        // Exception and redirect together: exception wins.
        exc_req         = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0400;
        step("both");
        exc_req         = 1'b0;
        redirect_valid  = 1'b0;
        check("both_pc", pc, EXC_VEC);
        step("both");

        // PC wraps past the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        step("wrap");
        redirect_valid  = 1'b0;
        step("wrap");
`ifndef DELAY_SLOT_EN
        check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc", pc, 32'h0000_0000);
`endif

        // Branch at 0x10 to 0x200: no delay slot without the macro.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0010;
        step("br");
        redirect_valid  = 1'b0;
        step("br");
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        step("br");
        redirect_valid  = 1'b0;
`ifndef DELAY_SLOT_EN
        check("br_addr", imem_addr, 32'h0000_0200);
`endif
        step("br");
`ifndef DELAY_SLOT_EN
        check("br_ipc", instr_pc, 32'h0000_0200);
`endif

        // Reset asserted while a fetch is outstanding.
        imem_ack = 1'b0;
        step("midrst");
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_req", imem_req, 1'b0);
        check("midrst_pc", pc, RST_VEC);
        check("midrst_valid", instr_valid, 1'b0);
        model_reset();
        @(negedge clock);
        compare_all("midrst");
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            imem_ack        = m_req && ($urandom_range(0, 2) != 0);
            imem_rdata      = $urandom;
            instr_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h0000_000F)) : $urandom;
            exc_req         = ($urandom_range(0, 24) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
